pipe5_rv_core: RTL and testbench

- Five-stage in-order pipelined RV32 integer core: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, data memory and register file.
- Includes load-use hazard detection, EX-stage forwarding, and branch resolution in ID with an IF flush.
- Top-level compute block of the teaching SoC. Its only external pins are clock, reset and start.

---
 rtl/pipe5_rv_core.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_pipe5_rv_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe5_rv_core.sv
`default_nettype none
// ============================================================================
// Module      : pipe5_rv_core (with helpers pipe5_imem, pipe5_dmem, pipe5_regfile)
// Description : Five-stage in-order RV32 integer core (IF, ID, EX, MEM, WB)
//               with private instruction memory, data memory and register
//               file. Load-use stall, EX-stage forwarding, and beq resolved
//               in ID with a one-cycle IF flush.
// Ports       : clk_i   - rising-edge clock
//               rst_i   - asynchronous active-low reset
//               start_i - run enable; the whole pipeline freezes while low
//               stall_cnt_o / flush_cnt_o (only with PERF_COUNTERS_EN)
// Options     : define PERF_COUNTERS_EN to add load-use stall and
//               taken-branch flush counters.
// Revision    : 1.0 - initial release
// ============================================================================

// Instruction memory: combinational read. The write port is tied off by the
// core; the array is filled by preloading.
module pipe5_imem #(
  parameter int WORDS = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [31:0]              rdata
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

// Data memory: byte array, little-endian word access, address wraps.
module pipe5_dmem #(
  parameter int BYTES = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(BYTES)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  localparam int AW = $clog2(BYTES);
  logic [7:0]    memory [0:BYTES-1];
  logic [AW-1:0] a0, a1, a2, a3;

  assign a0 = addr;
  assign a1 = addr + AW'(1);
  assign a2 = addr + AW'(2);
  assign a3 = addr + AW'(3);
  assign rdata = {memory[a3], memory[a2], memory[a1], memory[a0]};

  always_ff @(posedge clk) begin
    if (we) begin
      memory[a0] <= wdata[7:0];
      memory[a1] <= wdata[15:8];
      memory[a2] <= wdata[23:16];
      memory[a3] <= wdata[31:24];
    end
  end
endmodule

// Register file: x0 hard-wired to zero, write-first bypass on both reads.
module pipe5_regfile #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  localparam int AW = $clog2(N);
  logic [31:0] register [0:N-1];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : (we && wa == ra1) ? wd : register[ra1[AW-1:0]];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : (we && wa == ra2) ? wd : register[ra2[AW-1:0]];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) register[wa[AW-1:0]] <= wd;
  end
endmodule

module pipe5_rv_core #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32,
  parameter int NREG       = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_e;

  // IF
  logic [31:0] pc, if_instr;
  // IF/ID
  logic [31:0] ifid_pc, ifid_instr;
  // ID
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, br_target;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch;
  alu_op_e     id_alu_op;
  logic        stall, br_taken;
  // ID/EX
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src;
  alu_op_e     idex_alu_op;
  logic [4:0]  idex_rd, idex_rs1, idex_rs2;
  logic [31:0] idex_a, idex_b, idex_imm;
  // EX
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
  // EX/MEM
  logic        exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu, exmem_store, dmem_rdata;
  // MEM/WB
  logic        memwb_reg_write, memwb_mem_read;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_alu, memwb_load, wb_data;

  logic unused_bits;
  assign unused_bits = ^{pc[31:IAW+2], pc[1:0], exmem_alu[31:DAW]};

  // ---------------- IF ----------------
  pipe5_imem #(.WORDS(IMEM_WORDS)) u_imem (
    .clk(clk_i), .we(1'b0), .waddr('0), .wdata('0),
    .addr(pc[IAW+1:2]), .rdata(if_instr)
  );

  // ---------------- ID ----------------
  assign id_rs1 = ifid_instr[19:15];
  assign id_rs2 = ifid_instr[24:20];
  assign id_rd  = id_reg_write ? ifid_instr[11:7] : 5'd0;

  always_comb begin
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    id_alu_src   = 1'b0;
    id_branch    = 1'b0;
    id_alu_op    = ALU_ADD;
    id_imm       = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    case (ifid_instr[6:0])
      OP_R: begin
        case ({ifid_instr[31:25], ifid_instr[14:12]})
          {7'b0000000, 3'b000}: begin id_reg_write = 1'b1; id_alu_op = ALU_ADD; end
          {7'b0100000, 3'b000}: begin id_reg_write = 1'b1; id_alu_op = ALU_SUB; end
          {7'b0000001, 3'b000}: begin id_reg_write = 1'b1; id_alu_op = ALU_MUL; end
          {7'b0000000, 3'b001}: begin id_reg_write = 1'b1; id_alu_op = ALU_SLL; end
          {7'b0000000, 3'b100}: begin id_reg_write = 1'b1; id_alu_op = ALU_XOR; end
          {7'b0000000, 3'b111}: begin id_reg_write = 1'b1; id_alu_op = ALU_AND; end
          default: ;
        endcase
      end
      OP_IMM: begin
        if (ifid_instr[14:12] == 3'b000) begin
          id_reg_write = 1'b1;
          id_alu_src   = 1'b1;
        end else if (ifid_instr[14:12] == 3'b101 && ifid_instr[31:25] == 7'b0100000) begin
          id_reg_write = 1'b1;
          id_alu_src   = 1'b1;
          id_alu_op    = ALU_SRA;
        end
      end
      OP_LOAD: begin
        if (ifid_instr[14:12] == 3'b010) begin
          id_reg_write = 1'b1;
          id_mem_read  = 1'b1;
          id_alu_src   = 1'b1;
        end
      end
      OP_STORE: begin
        id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
        if (ifid_instr[14:12] == 3'b010) begin
          id_mem_write = 1'b1;
          id_alu_src   = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (ifid_instr[14:12] == 3'b000) id_branch = 1'b1;
      end
      default: ;
    endcase
  end

  pipe5_regfile #(.N(NREG)) u_rf (
    .clk(clk_i), .we(memwb_reg_write & start_i), .wa(memwb_rd), .wd(wb_data),
    .ra1(id_rs1), .ra2(id_rs2), .rd1(id_rd1), .rd2(id_rd2)
  );

  // Load in EX feeding the instruction in ID: hold one cycle.
  assign stall = idex_mem_read && (idex_rd != 5'd0) &&
                 (idex_rd == id_rs1 || idex_rd == id_rs2);

  // beq compares raw register-file outputs (no forwarding into ID).
  assign br_taken  = id_branch && (id_rd1 == id_rd2);
  assign br_target = ifid_pc + {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                                ifid_instr[30:25], ifid_instr[11:8], 1'b0};

  // ---------------- EX ----------------
  always_comb begin
    fwd_a = idex_a;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1)      fwd_a = exmem_alu;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1) fwd_a = wb_data;
    fwd_b = idex_b;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2)      fwd_b = exmem_alu;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2) fwd_b = wb_data;
  end

  assign alu_b = idex_alu_src ? idex_imm : fwd_b;

  always_comb begin
    alu_y = fwd_a + alu_b;
    case (idex_alu_op)
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_XOR: alu_y = fwd_a ^ alu_b;
      ALU_SLL: alu_y = fwd_a << alu_b[4:0];
      ALU_SRA: alu_y = 32'($signed(fwd_a) >>> alu_b[4:0]);
      ALU_MUL: alu_y = fwd_a * alu_b;
      default: ;
    endcase
  end

  // ---------------- MEM / WB ----------------
  pipe5_dmem #(.BYTES(DMEM_BYTES)) u_dmem (
    .clk(clk_i), .we(exmem_mem_write & start_i), .addr(exmem_alu[DAW-1:0]),
    .wdata(exmem_store), .rdata(dmem_rdata)
  );

  assign wb_data = memwb_mem_read ? memwb_load : memwb_alu;

  // ---------------- Pipeline registers ----------------
  // start_i low freezes every stage so no instruction is lost or repeated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc              <= '0;
      ifid_pc         <= '0;
      ifid_instr      <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_alu_op     <= ALU_ADD;
      idex_rd         <= '0;
      idex_rs1        <= '0;
      idex_rs2        <= '0;
      idex_a          <= '0;
      idex_b          <= '0;
      idex_imm        <= '0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_rd        <= '0;
      exmem_alu       <= '0;
      exmem_store     <= '0;
      memwb_reg_write <= 1'b0;
      memwb_mem_read  <= 1'b0;
      memwb_rd        <= '0;
      memwb_alu       <= '0;
      memwb_load      <= '0;
    end else if (start_i) begin
      // Stall wins over a taken branch; the branch re-evaluates next cycle.
      if (!stall) begin
        pc <= br_taken ? br_target : pc + 32'd4;
        if (br_taken) begin
          ifid_pc    <= '0;
          ifid_instr <= '0;
        end else begin
          ifid_pc    <= pc;
          ifid_instr <= if_instr;
        end
      end
      idex_reg_write  <= id_reg_write & ~stall;
      idex_mem_read   <= id_mem_read & ~stall;
      idex_mem_write  <= id_mem_write & ~stall;
      idex_alu_src    <= id_alu_src;
      idex_alu_op     <= id_alu_op;
      idex_rd         <= stall ? 5'd0 : id_rd;
      idex_rs1        <= id_rs1;
      idex_rs2        <= id_rs2;
      idex_a          <= id_rd1;
      idex_b          <= id_rd2;
      idex_imm        <= id_imm;
      exmem_reg_write <= idex_reg_write;
      exmem_mem_read  <= idex_mem_read;
      exmem_mem_write <= idex_mem_write;
      exmem_rd        <= idex_rd;
      exmem_alu       <= alu_y;
      exmem_store     <= fwd_b;
      memwb_reg_write <= exmem_reg_write;
      memwb_mem_read  <= exmem_mem_read;
      memwb_rd        <= exmem_rd;
      memwb_alu       <= exmem_alu;
      memwb_load      <= dmem_rdata;
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (start_i) begin
      if (stall)              stall_cnt_o <= stall_cnt_o + 32'd1;
      if (br_taken && !stall) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe5_rv_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe5_rv_core
// Description : Runs a short program on pipe5_rv_core and compares every
//               register-file writeback (register, value, clock edge)
//               against an expected queue, then checks memory, PC, pause
//               and mid-run reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe5_rv_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe5_rv_core dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .start_i(start)
`ifdef PERF_COUNTERS_EN
    ,
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [52:0] sb [$];   // {edge[15:0], rd[4:0], data[31:0]}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(input logic [12:0] off, input logic [4:0] rs1,
      input logic [4:0] rs2);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic expect_wb(input int rd, input logic [31:0] val, input int at);
    sb.push_back({16'(at), 5'(rd), val});
  endtask

  // Edge counter: edge 1 is the first rising edge with start high.
  always @(posedge clk) if (rst_n && start) cyc++;

  // Writeback monitor: MEM/WB contents seen at the falling edge are written
  // on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && start && dut.memwb_reg_write && dut.memwb_rd != 5'd0) begin
      logic [52:0] obs;
      obs = {16'(cyc + 1), dut.memwb_rd, dut.wb_data};
      if (sb.size() == 0) check("wb_unexpected", 64'(obs), 64'd0);
      else check("wb", 64'(obs), 64'(sb.pop_front()));
    end
  end

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  initial begin
    for (int i = 0; i < 256; i++) dut.u_imem.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++)  dut.u_dmem.memory[i] = 8'd0;
    for (int i = 0; i < 32; i++)  dut.u_rf.register[i] = 32'd0;
    dut.u_dmem.memory[0] = 8'd5;

    dut.u_imem.memory[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);            expect_wb(1, 32'd5, 5);
    dut.u_imem.memory[1]  = enc_i(12'd3, 5'd0, 3'b000, 5'd2, OPI);            expect_wb(2, 32'd3, 6);
    dut.u_imem.memory[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);           expect_wb(3, 32'd8, 7);
    dut.u_imem.memory[3]  = enc_i(12'd0, 5'd0, 3'b010, 5'd4, OPL);            expect_wb(4, 32'd5, 8);
    dut.u_imem.memory[4]  = enc_i(12'd1, 5'd4, 3'b000, 5'd5, OPI);            expect_wb(5, 32'd6, 10);
    dut.u_imem.memory[5]  = enc_sw(12'd4, 5'd3, 5'd0);
    dut.u_imem.memory[6]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd7);           expect_wb(7, 32'd2, 12);
    dut.u_imem.memory[7]  = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd8);           expect_wb(8, 32'd15, 13);
    dut.u_imem.memory[8]  = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd9);           expect_wb(9, 32'd40, 14);
    dut.u_imem.memory[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10);          expect_wb(10, 32'd6, 15);
    dut.u_imem.memory[10] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd11);          expect_wb(11, 32'd1, 16);
    dut.u_imem.memory[11] = enc_i(12'hFF8, 5'd0, 3'b000, 5'd12, OPI);         expect_wb(12, 32'hFFFF_FFF8, 17);
    dut.u_imem.memory[12] = enc_i(12'h401, 5'd12, 3'b101, 5'd13, OPI);        expect_wb(13, 32'hFFFF_FFFC, 18);
    dut.u_imem.memory[13] = enc_i(12'd7, 5'd0, 3'b000, 5'd6, OPI);            expect_wb(6, 32'd7, 19);
    dut.u_imem.memory[14] = enc_beq(13'd8, 5'd1, 5'd2);
    dut.u_imem.memory[15] = enc_i(12'd11, 5'd0, 3'b000, 5'd18, OPI);          expect_wb(18, 32'd11, 21);
    dut.u_imem.memory[17] = enc_beq(13'd8, 5'd6, 5'd6);
    dut.u_imem.memory[18] = enc_i(12'd99, 5'd0, 3'b000, 5'd14, OPI);
    dut.u_imem.memory[19] = enc_i(12'd42, 5'd0, 3'b000, 5'd15, OPI);          expect_wb(15, 32'd42, 25);
    dut.u_imem.memory[20] = enc_i(12'd4, 5'd0, 3'b010, 5'd16, OPL);           expect_wb(16, 32'd8, 26);
    dut.u_imem.memory[21] = enc_r(7'h00, 5'd16, 5'd16, 3'b000, 5'd17);        expect_wb(17, 32'd16, 28);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pc", 64'(dut.pc), 64'd0);
    check("rst_pipe", 64'({dut.ifid_instr, dut.idex_reg_write, dut.idex_mem_read,
          dut.idex_mem_write, dut.exmem_reg_write, dut.exmem_mem_write,
          dut.memwb_reg_write, dut.idex_rd, dut.exmem_rd, dut.memwb_rd}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pc_hold_idle", 64'(dut.pc), 64'd0);
    end

    start = 1'b1;
    repeat (40) @(negedge clk);
    // 40 edges minus two load-use stalls; the taken beq lands on PC+4 anyway.
    check("pc_run", 64'(dut.pc), 64'd152);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("dmem_word4", 64'({dut.u_dmem.memory[7], dut.u_dmem.memory[6],
          dut.u_dmem.memory[5], dut.u_dmem.memory[4]}), 64'd8);
    check("flushed_x14", 64'(dut.u_rf.register[14]), 64'd0);
`ifdef PERF_COUNTERS_EN
    check("stall_cnt", 64'(stall_cnt), 64'd2);
    check("flush_cnt", 64'(flush_cnt), 64'd1);
`endif

    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pc_hold_pause", 64'(dut.pc), 64'd152);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("pc_resume", 64'(dut.pc), 64'd160);

    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_pc", 64'(dut.pc), 64'd0);
    check("midrst_pipe", 64'({dut.ifid_instr, dut.idex_reg_write, dut.exmem_reg_write,
          dut.memwb_reg_write}), 64'd0);
    check("keep_x3", 64'(dut.u_rf.register[3]), 64'd8);
    check("keep_x13", 64'(dut.u_rf.register[13]), 64'hFFFF_FFFC);
    check("keep_dmem", 64'({dut.u_dmem.memory[7], dut.u_dmem.memory[6],
          dut.u_dmem.memory[5], dut.u_dmem.memory[4]}), 64'd8);
`ifdef PERF_COUNTERS_EN
    check("midrst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
`endif
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
